// File: rtl/mux_scan_n_1.sv
// ---------------------------------------------------------------------------
// mux_scan_n_1
//
// Registered N_CH-channel, W-bit multiplexer with two modes:
//   manual - the channel is taken from sel
//   scan   - an internal round-robin pointer visits every channel and holds
//            each one for DWELL cycles
// Every output word carries the index of the channel it came from.
//
// Ports:
//   clk      in   1          system clock, rising edge
//   rst_n    in   1          asynchronous reset, active low
//   en       in   1          block enable; low pauses the block (IDLE)
//   mode     in   1          0 = manual, 1 = scan
//   sel      in   SEL_W      manual channel select
//   din      in   N_CH*W     packed channels, channel k = din[k*W +: W]
//   y        out  W          registered selected data
//   y_ch     out  SEL_W      channel index belonging to y
//   y_valid  out  1          y / y_ch valid this cycle
//   wrap     out  1          one-cycle pulse on the first word after the
//                            scan pointer has returned from N_CH-1 to 0
// ---------------------------------------------------------------------------
module mux_scan_n_1 #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int DWELL = 4,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_CH*W-1:0]  din,
  output logic [W-1:0]       y,
  output logic [SEL_W-1:0]   y_ch,
  output logic               y_valid,
  output logic               wrap
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               pend_reg, pend_next;
  logic [W-1:0]       y_reg, y_next;
  logic [SEL_W-1:0]   ych_reg, ych_next;
  logic               yv_reg, yv_next;
  logic               wrap_reg, wrap_next;

  // Unpacked view of the channel bus.
  logic [W-1:0] ch_data [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = din[gi*W +: W];
    end
  endgenerate

  // Effective scan position for this edge. Coming out of MAN the scan
  // restarts at channel 0 with a fresh dwell, and any wrap that was still
  // waiting to be reported belongs to the abandoned sweep, so drop it.
  logic [SEL_W-1:0] scan_ptr;
  logic [CNT_W-1:0] scan_cnt;
  logic             scan_pend;
  logic             sel_in_range;
  logic [W-1:0]     man_data;
  logic [W-1:0]     scan_data;

  always_comb begin
    scan_ptr  = ptr_reg;
    scan_cnt  = cnt_reg;
    scan_pend = pend_reg;
    if (state_reg == MAN) begin
      scan_ptr  = '0;
      scan_cnt  = '0;
      scan_pend = 1'b0;
    end
  end

  // sel can exceed N_CH-1 when N_CH is not a power of two; those codes
  // select nothing and produce zero data.
  always_comb begin
    sel_in_range = (int'(sel) < N_CH);
    man_data     = '0;
    scan_data    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(sel) == k) begin
        man_data = ch_data[k];
      end
      if (int'(scan_ptr) == k) begin
        scan_data = ch_data[k];
      end
    end
  end

  // Next-state and output logic. The action taken on an edge is the one
  // of the state being entered, which gives one clock of latency from
  // en/mode/sel/din to y.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    y_next     = y_reg;
    ych_next   = ych_reg;
    yv_next    = 1'b0;
    wrap_next  = 1'b0;

    if (!en) begin
      // Pause: data and index hold, scan position freezes.
      state_next = IDLE;
    end else if (!mode) begin
      state_next = MAN;
      ych_next   = sel;
      if (sel_in_range) begin
        y_next  = man_data;
        yv_next = 1'b1;
      end else begin
        y_next  = '0;
        yv_next = 1'b0;
      end
    end else begin
      state_next = SCAN;
      y_next     = scan_data;
      ych_next   = scan_ptr;
      yv_next    = 1'b1;
      // wrap is reported together with the first channel-0 word of the
      // new sweep, then cleared.
      wrap_next  = scan_pend;
      pend_next  = 1'b0;
      ptr_next   = scan_ptr;
      if (int'(scan_cnt) == DWELL - 1) begin
        cnt_next = '0;
        if (int'(scan_ptr) == N_CH - 1) begin
          ptr_next  = '0;
          pend_next = 1'b1;
        end else begin
          ptr_next = scan_ptr + 1'b1;
        end
      end else begin
        cnt_next = scan_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      pend_reg  <= 1'b0;
      y_reg     <= '0;
      ych_reg   <= '0;
      yv_reg    <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
      y_reg     <= y_next;
      ych_reg   <= ych_next;
      yv_reg    <= yv_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign y       = y_reg;
  assign y_ch    = ych_reg;
  assign y_valid = yv_reg;
  assign wrap    = wrap_reg;

endmodule

// File: tb/tb_mux_scan_n_1.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_n_1
//
// Two instances share clk/rst_n/en/mode:
//   A: N_CH=4, W=8, DWELL=4   (directed sweep, pause, restart, reset)
//   B: N_CH=5, W=8, DWELL=1   (out-of-range select, per-cycle scan)
// A behavioural model (channel pointer + dwell counter as plain integers)
// predicts every output; one process compares after every clock edge and
// after an asynchronous reset. Directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_mux_scan_n_1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  sel_a = '0;
  logic [2:0]  sel_b = '0;
  logic [31:0] din_a = '0;
  logic [39:0] din_b = '0;

  logic [7:0]  y_a, y_b;
  logic [1:0]  ych_a;
  logic [2:0]  ych_b;
  logic        yv_a, yv_b, wrap_a, wrap_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_scan_n_1 #(.N_CH(4), .W(8), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_a),
    .din(din_a), .y(y_a), .y_ch(ych_a), .y_valid(yv_a), .wrap(wrap_a)
  );

  mux_scan_n_1 #(.N_CH(5), .W(8), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_b),
    .din(din_b), .y(y_b), .y_ch(ych_b), .y_valid(yv_b), .wrap(wrap_b)
  );

  // ---------------- behavioural model ----------------
  // m_st: 0 paused/reset, 1 manual, 2 scan
  int  m_n[2]     = '{4, 5};
  int  m_dwell[2] = '{4, 1};
  int  m_st[2]    = '{0, 0};
  int  m_ptr[2]   = '{0, 0};
  int  m_cnt[2]   = '{0, 0};
  int  m_y[2]     = '{0, 0};
  int  m_ych[2]   = '{0, 0};
  bit  m_pend[2]  = '{0, 0};
  bit  m_yv[2]    = '{0, 0};
  bit  m_wrap[2]  = '{0, 0};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0; m_y[i] = 0; m_ych[i] = 0;
      m_pend[i] = 0; m_yv[i] = 0; m_wrap[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit e, input bit m,
                            input int s, input logic [63:0] d);
    if (!e) begin
      m_st[i] = 0; m_yv[i] = 0; m_wrap[i] = 0;
    end else if (!m) begin
      m_st[i] = 1; m_ych[i] = s; m_wrap[i] = 0;
      if (s < m_n[i]) begin
        m_y[i] = int'((d >> (s*8)) & 64'hFF); m_yv[i] = 1;
      end else begin
        m_y[i] = 0; m_yv[i] = 0;
      end
    end else begin
      if (m_st[i] == 1) begin
        m_ptr[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
      end
      m_st[i]   = 2;
      m_y[i]    = int'((d >> (m_ptr[i]*8)) & 64'hFF);
      m_ych[i]  = m_ptr[i];
      m_yv[i]   = 1;
      m_wrap[i] = m_pend[i];
      m_pend[i] = 0;
      m_cnt[i]++;
      if (m_cnt[i] == m_dwell[i]) begin
        m_cnt[i] = 0;
        m_ptr[i]++;
        if (m_ptr[i] == m_n[i]) begin
          m_ptr[i] = 0;
          m_pend[i] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, en, mode, int'(sel_a), {32'd0, din_a});
      model_step(1, en, mode, int'(sel_b), {24'd0, din_b});
    end
    #1;
    chk("a.y",     {56'd0, y_a},    64'(m_y[0]));
    chk("a.y_ch",  {62'd0, ych_a},  64'(m_ych[0]));
    chk("a.valid", {63'd0, yv_a},   64'(m_yv[0]));
    chk("a.wrap",  {63'd0, wrap_a}, 64'(m_wrap[0]));
    chk("b.y",     {56'd0, y_b},    64'(m_y[1]));
    chk("b.y_ch",  {61'd0, ych_b},  64'(m_ych[1]));
    chk("b.valid", {63'd0, yv_b},   64'(m_yv[1]));
    chk("b.wrap",  {63'd0, wrap_b}, 64'(m_wrap[1]));
  end

  // ---------------- stimulus + directed literal checks ----------------
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic chk_a(input string name, input int ch, input bit v,
                       input bit w);
    logic [31:0] da;
    da = din_a;
    $display("txn %s: y=%02h y_ch=%0d valid=%0b wrap=%0b", name, y_a, ych_a, yv_a, wrap_a);
    chk({name, ".y_ch"},  {62'd0, ych_a},  64'(ch));
    chk({name, ".y"},     {56'd0, y_a},    64'((da >> (ch*8)) & 32'hFF));
    chk({name, ".valid"}, {63'd0, yv_a},   64'(v));
    chk({name, ".wrap"},  {63'd0, wrap_a}, 64'(w));
  endtask

  initial begin
    din_a = 32'hD3C2B1A0;
    din_b = 40'h9E8D7C6B5A;

    // Reset state
    next_cyc();
    next_cyc();
    chk("rst.y",     {56'd0, y_a},   64'd0);
    chk("rst.y_ch",  {62'd0, ych_a}, 64'd0);
    chk("rst.valid", {63'd0, yv_a},  64'd0);
    rst_n = 1'b1;

    // Manual select (A) and out-of-range select (B)
    en = 1'b1; mode = 1'b0; sel_a = 2'd2; sel_b = 3'd6;
    next_cyc();
    chk("man.y",       {56'd0, y_a},   64'hC2);
    chk("man.y_ch",    {62'd0, ych_a}, 64'd2);
    chk("man.valid",   {63'd0, yv_a},  64'd1);
    chk("oor.y",       {56'd0, y_b},   64'h00);
    chk("oor.y_ch",    {61'd0, ych_b}, 64'd6);
    chk("oor.valid",   {63'd0, yv_b},  64'd0);
    sel_a = 2'd3; sel_b = 3'd4;
    next_cyc();
    chk("man3.y",      {56'd0, y_a},   64'hD3);
    chk("sel4.y",      {56'd0, y_b},   64'h9E);
    chk("sel4.valid",  {63'd0, yv_b},  64'd1);

    // Scan sweep from MAN: 0x4,1x4,2x4,3x4,0 with wrap on word 17
    mode = 1'b1;
    for (int i = 0; i < 17; i++) begin
      next_cyc();
      chk_a($sformatf("sweep%0d", i), (i / 4) % 4, 1'b1, i == 16);
    end
    // Advance to ptr=2 with one word of channel 2 already produced
    for (int i = 0; i < 8; i++) next_cyc();
    chk_a("pre_pause", 2, 1'b1, 1'b0);

    // Pause for 5 cycles
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      chk_a($sformatf("pause%0d", i), 2, 1'b0, 1'b0);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      chk_a($sformatf("resume%0d", i), 2, 1'b1, 1'b0);
    end
    next_cyc();
    chk_a("resume_ch3", 3, 1'b1, 1'b0);

    // Mode switch at ptr=3 restarts scan at channel 0 with a full dwell
    mode = 1'b0; sel_a = 2'd1;
    next_cyc();
    chk_a("sw_man0", 1, 1'b1, 1'b0);
    next_cyc();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      chk_a($sformatf("restart%0d", i), (i < 4) ? 0 : 1, 1'b1, 1'b0);
    end

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.y",     {56'd0, y_a},   64'd0);
    chk("arst.y_ch",  {62'd0, ych_a}, 64'd0);
    chk("arst.valid", {63'd0, yv_a},  64'd0);
    next_cyc();
    rst_n = 1'b1; en = 1'b1; mode = 1'b1;
    next_cyc();
    chk_a("post_rst", 0, 1'b1, 1'b0);

    // Randomised traffic, checked by the compare process
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 7) != 0);
      mode  = ($urandom_range(0, 3) != 0);
      sel_a = 2'($urandom_range(0, 3));
      sel_b = 3'($urandom_range(0, 7));
      din_a = $urandom;
      din_b = {8'($urandom), 32'($urandom)};
      next_cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_n_1.md
Name: mux_scan_n_1

Overview:
Parametrised, registered N-channel, W-bit multiplexer that generalises the combinational N:1 mux. It has two modes. In manual mode the channel comes from `sel`. In scan mode an internal round-robin pointer steps through the channels, holding each one for DWELL cycles. It sits between multi-channel sensor/data sources and a single serial consumer (display or UART front-end), and tags every output word with its channel index.

Parameters:
N_CH, 4, number of input channels (>=2)
W, 8, bits per channel
DWELL, 4, cycles each channel is held in scan mode (>=1)
SEL_W, $clog2(N_CH), width of the channel index (derived; never overridden)

Ports:
clk      input   1           system clock, rising edge
rst_n    input   1           asynchronous reset, active-low
en       input   1           block enable; low = pause
mode     input   1           0 = manual, 1 = scan
sel      input   SEL_W       manual channel select
din      input   N_CH*W      packed channels; channel k = din[k*W +: W]
y        output  W           registered selected data
y_ch     output  SEL_W       channel index of the current y
y_valid  output  1           y/y_ch valid this cycle
wrap     output  1           one-cycle pulse when the scan pointer returns from N_CH-1 to 0

Behaviour:
- Reset (rst_n=0, asynchronous, no clock needed): y=0, y_ch=0, y_valid=0, wrap=0, ptr=0, dwell_cnt=0, state=IDLE.
- All outputs are registered. Latency is 1 clock from din/sel/mode/en to y.
- States:
  - IDLE: entered from reset.
  - MAN: manual mode.
  - SCAN: scan mode.
- Transitions on each rising edge:
  - en=0 → IDLE.
  - en=1, mode=0 → MAN.
  - en=1, mode=1 → SCAN.
- IDLE:
  - y and y_ch hold their last values; y_valid=0; wrap=0.
  - ptr and dwell_cnt freeze, so a scan paused by en=0 resumes at the same channel and dwell count.
- MAN:
  - If sel < N_CH: y <= din[sel*W +: W], y_ch <= sel, y_valid <= 1.
  - If sel >= N_CH (non-power-of-2 N_CH): y <= 0, y_ch <= sel, y_valid <= 0.
  - ptr and dwell_cnt are untouched in MAN.
- Entering SCAN from MAN: ptr <= 0, dwell_cnt <= 0. Scanning restarts at channel 0.
- Entering SCAN from IDLE: no pointer or count reset (resume).
- SCAN, every cycle:
  - y <= din[ptr*W +: W], y_ch <= ptr, y_valid <= 1.
  - If dwell_cnt == DWELL-1: dwell_cnt <= 0 and ptr advances. Otherwise dwell_cnt increments.
  - ptr advance: ptr == N_CH-1 → ptr <= 0 and wrap <= 1 for exactly that cycle; else ptr <= ptr+1.
- din is sampled live every cycle, so channel data changing during a dwell is visible on y the next cycle.
- DWELL=1: the channel changes every cycle, and wrap pulses every N_CH cycles.
- Mode change mid-dwell takes effect on the next edge. There are no glitches and no partial-dwell outputs after the switch.
- Reset asserted mid-scan forces the reset values immediately. The first SCAN after release starts at channel 0.

Test Plan:
1. Reset/manual: N_CH=4, W=8, din={8'hD3,8'hC2,8'hB1,8'hA0}, en=1, mode=0, sel=2.
   → One cycle after sel=2: y=8'hC2, y_ch=2, y_valid=1. Then sel=3 → y=8'hD3 next cycle.
2. Scan sweep: DWELL=4, mode=1 from MAN.
   → y_ch sequence 0,0,0,0,1,1,1,1,2,...,3,3,3,3,0.
   → y matches each channel's data.
   → wrap=1 only on the single cycle y_ch first returns to 0 (cycle 17 after entry).
3. Pause/resume: in SCAN, drop en at ptr=2, dwell_cnt=1 for 5 cycles.
   → y and y_ch held at channel 2, y_valid=0, wrap=0.
   → Re-raise en: 3 more cycles of channel 2, then channel 3.
4. Mode switch restart: SCAN at ptr=3, switch to mode=0 for 2 cycles, then back to mode=1.
   → Scan resumes at y_ch=0 with a full 4-cycle dwell.
5. Out-of-range select: N_CH=5, sel=6 in MAN.
   → y=0, y_valid=0, y_ch=6. Then sel=4 → y=channel 4 data, y_valid=1.
6. Async reset mid-scan: pull rst_n low between clock edges.
   → All outputs are 0 before the next clk edge. After release with en=1, mode=1, the first output is y_ch=0.
